// File: rtl/mult_seq_accum.sv
`timescale 1ns/1ps
// mult_seq_accum: walks an external pair of 8x8 multipliers through the byte
// combinations of 8/16/32-bit elements and assembles a 64-bit product.
module mult_seq_accum (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  sew,
    input  logic [15:0] mult1_P,
    input  logic [15:0] mult2_P,
    output logic [1:0]  count_16bit,
    output logic [3:0]  count_32bit,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEW_8   = 2'b00;
    localparam logic [1:0] SEW_16  = 2'b01;
    localparam logic [1:0] SEW_BAD = 2'b11;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [1:0]        sew_reg, sew_next;
    logic [63:0]       product_reg, product_next;
    logic              err_reg, err_next;
    logic [3:0]        last_cnt;
    logic [1:0]        shift16;
    logic [2:0]        shift32;
    logic [1:0][15:0]  lane_p;
    logic [1:0][31:0]  lane_sum;
    logic [63:0]       full_sum;

    // Final step index for the latched element width.
    always_comb begin
        case (sew_reg)
            SEW_8:   last_cnt = 4'd1;
            SEW_16:  last_cnt = 4'd3;
            default: last_cnt = 4'd15;
        endcase
    end

    // Byte weight of the current partial product is i+j.
    assign shift16 = {1'b0, cnt_reg[0]} + {1'b0, cnt_reg[1]};
    assign shift32 = {1'b0, cnt_reg[1:0]} + {1'b0, cnt_reg[3:2]};
    assign lane_p  = {mult2_P, mult1_P};

    // Two independent 32-bit lanes for 16-bit elements; carries stay inside a lane.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_sum[gi] = product_reg[32*gi +: 32]
                                + ({16'b0, lane_p[gi]} << {shift16, 3'b000});
        end
    endgenerate

    // Single 64-bit accumulation for 32-bit elements; multiplier 2 is unused.
    assign full_sum = product_reg + ({48'b0, mult1_P} << {shift32, 3'b000});

    // Next-state, step counter and accumulator update.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        sew_next     = sew_reg;
        product_next = product_reg;
        err_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (sew == SEW_BAD) begin
                        err_next = 1'b1;
                    end else begin
                        sew_next     = sew;
                        cnt_next     = 4'd0;
                        product_next = 64'd0;
                        state_next   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                case (sew_reg)
                    SEW_8: begin
                        // Four 8-bit elements: mult1 fills lanes 0/1, mult2 lanes 2/3.
                        product_next[{cnt_reg[0], 4'b0000} +: 16]       = mult1_P;
                        product_next[{1'b1, cnt_reg[0], 4'b0000} +: 16] = mult2_P;
                    end
                    SEW_16:  product_next = {lane_sum[1], lane_sum[0]};
                    default: product_next = full_sum;
                endcase
                if (cnt_reg == last_cnt) begin
                    cnt_next   = 4'd0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            sew_reg     <= 2'b00;
            product_reg <= 64'd0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            sew_reg     <= sew_next;
            product_reg <= product_next;
            err_reg     <= err_next;
        end
    end

    // Operand-mux byte selects, only meaningful while running.
    always_comb begin
        count_16bit = 2'b00;
        count_32bit = 4'b0000;
        if (state_reg == ST_RUN) begin
            case (sew_reg)
                SEW_8:   count_16bit = {1'b0, cnt_reg[0]};
                SEW_16:  count_16bit = cnt_reg[1:0];
                default: count_32bit = cnt_reg;
            endcase
        end
    end

    assign busy    = (state_reg == ST_RUN);
    assign done    = (state_reg == ST_DONE);
    assign err     = err_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_mult_seq_accum.sv
`timescale 1ns/1ps
// tb_mult_seq_accum: emulates the operand mux and multipliers around the DUT
// and checks results against element-wise arithmetic.
module tb_mult_seq_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  sew = 2'b00;
    logic [15:0] mult1_P, mult2_P;
    logic [1:0]  count_16bit;
    logic [3:0]  count_32bit;
    logic        busy, done, err;
    logic [63:0] product;

    logic [31:0] op_a = '0, op_b = '0;
    logic [1:0]  md = 2'd0;       // 0..2: operand mux per element width, 3: direct table
    logic [15:0] p1_tab [2];
    logic [15:0] p2_tab [2];

    int total = 0;
    int bad = 0;

    mult_seq_accum dut (
        .clk(clk), .reset(reset), .start(start), .sew(sew),
        .mult1_P(mult1_P), .mult2_P(mult2_P),
        .count_16bit(count_16bit), .count_32bit(count_32bit),
        .busy(busy), .done(done), .err(err), .product(product)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
        return {8'b0, x} * {8'b0, y};
    endfunction

    // Upstream operand mux plus two 8x8 multipliers.
    always_comb begin
        mult1_P = 16'h0000;
        mult2_P = 16'h0000;
        case (md)
            2'd0: begin
                mult1_P = mul8(op_a[8*count_16bit[0] +: 8], op_b[8*count_16bit[0] +: 8]);
                mult2_P = mul8(op_a[16 + 8*count_16bit[0] +: 8], op_b[16 + 8*count_16bit[0] +: 8]);
            end
            2'd1: begin
                mult1_P = mul8(op_a[8*count_16bit[0] +: 8], op_b[8*count_16bit[1] +: 8]);
                mult2_P = mul8(op_a[16 + 8*count_16bit[0] +: 8], op_b[16 + 8*count_16bit[1] +: 8]);
            end
            2'd2: begin
                mult1_P = mul8(op_a[8*count_32bit[1:0] +: 8], op_b[8*count_32bit[3:2] +: 8]);
                mult2_P = 16'hBEEF;
            end
            default: begin
                mult1_P = p1_tab[count_16bit[0]];
                mult2_P = p2_tab[count_16bit[0]];
            end
        endcase
    end

    // Element-wise reference result.
    function automatic logic [63:0] model(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = '0;
        case (s)
            2'd0: for (int l = 0; l < 4; l++) r[16*l +: 16] = mul8(a[8*l +: 8], b[8*l +: 8]);
            2'd1: begin
                r[31:0]  = {16'b0, a[15:0]}  * {16'b0, b[15:0]};
                r[63:32] = {16'b0, a[31:16]} * {16'b0, b[31:16]};
            end
            default: r = {32'b0, a} * {32'b0, b};
        endcase
        return r;
    endfunction

    function automatic int steps(input logic [1:0] s);
        return (s == 2'd0) ? 2 : (s == 2'd1) ? 4 : 16;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // One multiply: pulse start, follow every cycle to a few past done.
    task automatic run_op(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                          input bit direct, input logic [63:0] want, input string name);
        int n, done_cyc, c;
        bit seq_ok;
        logic [1:0] e16;
        logic [3:0] e32;
        n = steps(s);
        done_cyc = 0;
        seq_ok = 1'b1;
        @(negedge clk);
        op_a = a; op_b = b; sew = s; md = direct ? 2'd3 : s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= n + 3; cyc++) begin
            @(negedge clk);
            c = cyc - 1;
            e16 = 2'b00;
            e32 = 4'b0000;
            if (cyc <= n) begin
                if (s == 2'd0) e16 = {1'b0, c[0]};
                else if (s == 2'd1) e16 = c[1:0];
                else e32 = c[3:0];
            end
            if (busy !== (cyc <= n)) seq_ok = 1'b0;
            if (count_16bit !== e16 || count_32bit !== e32) seq_ok = 1'b0;
            if (err !== 1'b0) seq_ok = 1'b0;
            if (done === 1'b1) done_cyc = (done_cyc == 0) ? cyc : -1;
        end
        $display("op %s sew=%0d a=%h b=%h product=%h done_cycle=%0d", name, s, a, b, product, done_cyc);
        chk({name, "_lat"}, 64'(done_cyc), 64'(n + 1));
        chk({name, "_seq"}, 64'(seq_ok), 64'd1);
        chk({name, "_prod"}, product, want);
    endtask

    typedef struct {
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] want;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] last_p;
        int dn, d1, d2, busy4;
        bit hit;

        vecs[0] = '{2'b01, 32'h00FF00FF, 32'h00FF00FF, 64'h0000FE01_0000FE01};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFE0001_FFFE0001};
        vecs[2] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[3] = '{2'b00, 32'h04030201, 32'h08070605, 64'h0020_0015_000C_0005};
        vecs[4] = '{2'b01, 32'h00020003, 32'h00040005, 64'h00000008_0000000F};
        vecs[5] = '{2'b10, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
        p1_tab[0] = 16'h0002; p1_tab[1] = 16'h0003;
        p2_tab[0] = 16'h0010; p2_tab[1] = 16'h00FF;

        // Reset state.
        #12;
        chk("rst_product", product, 64'd0);
        chk("rst_flags", {61'd0, busy, done, err}, 64'd0);
        chk("rst_counts", {58'd0, count_16bit, count_32bit}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 8-bit mode with directly supplied partial products.
        run_op(2'b00, 32'h0, 32'h0, 1'b1, 64'h00FF_0010_0003_0002, "direct8");

        // Table vectors.
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, vecs[i].want, $sformatf("vec%0d", i));
        last_p = vecs[5].want;

        // Illegal width: err pulse, never busy, product held.
        @(negedge clk);
        sew = 2'b11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        $display("op illegal sew=3 err=%b busy=%b", err, busy);
        chk("err_pulse", {62'd0, err, busy}, 64'd2);
        @(negedge clk);
        chk("err_clear", {62'd0, err, busy}, 64'd0);
        chk("err_prod_held", product, last_p);

        // Start held high: one done per accepted start, re-accept only from idle.
        @(negedge clk);
        op_a = 32'h11223344; op_b = 32'h55667788; sew = 2'b00; md = 2'd0; start = 1'b1;
        dn = 0; d1 = 0; d2 = 0; busy4 = -1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 8) start = 1'b0;
            if (cyc == 4) busy4 = int'(busy);
            if (done === 1'b1) begin
                dn++;
                if (d1 == 0) d1 = cyc; else d2 = cyc;
            end
        end
        $display("op held_start done_count=%0d at %0d,%0d", dn, d1, d2);
        chk("held_done_cnt", 64'(dn), 64'd2);
        chk("held_done_pos", {32'(d1), 32'(d2)}, {32'd3, 32'd7});
        chk("held_idle_gap", 64'(busy4), 64'd0);
        chk("held_prod", product, model(2'b00, 32'h11223344, 32'h55667788));

        // Reset at step 2 of a 32-bit run: immediate clear and no done.
        @(negedge clk);
        op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; sew = 2'b10; md = 2'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int cyc = 1; cyc <= 10 && !hit; cyc++) begin
            @(negedge clk);
            if (count_32bit == 4'd2 && busy) hit = 1'b1;
        end
        chk("rst_reach_step2", 64'(hit), 64'd1);
        reset = 1'b0;
        #1;
        $display("op midrun_reset product=%h busy=%b done=%b", product, busy, done);
        chk("midrst_product", product, 64'd0);
        chk("midrst_flags", {58'd0, busy, done, err, count_16bit[0], count_16bit[1], |count_32bit}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        run_op(2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b0, model(2'b01, 32'h12345678, 32'h9ABCDEF0), "post_rst");

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 25; i++) begin
            logic [1:0]  rs;
            logic [31:0] ra, rb;
            rs = 2'($urandom_range(0, 2));
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'hFFFFFFFF : $urandom;
            run_op(rs, ra, rb, 1'b0, model(rs, ra, rb), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_seq_accum.md
MULT_SEQ_ACCUM -- requirements
Module: mult_seq_accum

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low reset; clears all state immediately.
REQ-003 start  input  1  request for a new multiply; sampled only in IDLE.
REQ-004 sew  input  2  element width: 00=8-bit, 01=16-bit, 10=32-bit, 11=illegal; latched on start acceptance.
REQ-005 mult1_P  input  16  unsigned 8x8 product from multiplier 1, same-cycle combinational.
REQ-006 mult2_P  input  16  unsigned 8x8 product from multiplier 2, same-cycle combinational.
REQ-007 count_16bit  output  2  byte-select step for the operand mux; 8-bit and 16-bit modes.
REQ-008 count_32bit  output  4  byte-select step for the operand mux; 32-bit mode.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  one-cycle pulse; product is valid.
REQ-011 err  output  1  one-cycle pulse; start was sampled with sew=11.
REQ-012 product  output  64  assembled result; held until the next accepted start.

Function
REQ-013 FSM states are IDLE, RUN and DONE.
REQ-014 IDLE & start & sew!=11: latch sew, clear step counter and product accumulator, go to RUN.
REQ-015 IDLE & start & sew==11: stay in IDLE; pulse err next cycle; product unchanged.
REQ-016 Step count N: 2 for sew 00, 4 for sew 01, 16 for sew 10.
REQ-017 RUN: counter c runs 0..N-1, one step per cycle; on the edge at c==N-1, go to DONE.
REQ-018 DONE lasts one cycle with done=1, then goes to IDLE.
REQ-019 start is ignored in RUN and DONE.
REQ-020 Latency: start sampled on edge E0; RUN occupies cycles 1..N; done is high in cycle N+1.
REQ-021 Outputs in sew 00: count_16bit={0,c[0]}, count_32bit=0.
REQ-022 Outputs in sew 01: count_16bit=c[1:0], count_32bit=0.
REQ-023 Outputs in sew 10: count_32bit=c[3:0], count_16bit=0.
REQ-024 Both count outputs are 0 outside RUN.
REQ-025 sew 00, step k: product[16k+15:16k] <= mult1_P; product[16(k+2)+15:16(k+2)] <= mult2_P.
REQ-026 sew 01, step c, with i=c[0], j=c[1]: product[31:0] += mult1_P<<8(i+j), modulo 2^32.
REQ-027 sew 01, same step: product[63:32] += mult2_P<<8(i+j), modulo 2^32; no carry crosses bit 31 to 32.
REQ-028 sew 10, step c, with i=c[1:0], j=c[3:2]: product += mult1_P<<8(i+j), modulo 2^64; mult2_P ignored.
REQ-029 All arithmetic is unsigned. Operands are guaranteed stable upstream while busy; the block does not check this.
REQ-030 busy=1 exactly in RUN; done and err are never high together.

Reset
REQ-031 While reset=0: state=IDLE, c=0, product=0, busy=0, done=0, err=0, count_16bit=0, count_32bit=0.
REQ-032 Reset mid-RUN aborts with no done pulse; the first start after reset release behaves as after power-up.

Verification
REQ-033 sew=00; products per step: step0 (P1,P2)=(0x0002,0x0010), step1=(0x0003,0x00FF) -> done in cycle 3; product=0x00FF_0010_0003_0002; count_16bit seq 0,1.
REQ-034 sew=01; A=0x00FF_00FF, B=0x00FF_00FF; model mult1_P/mult2_P from the operand mux -> done in cycle 5; product=0x0000FE01_0000FE01.
REQ-035 sew=01; A=B=0xFFFF_FFFF -> product=0xFFFE0001_FFFE0001; no carry between lanes.
REQ-036 sew=10; A=B=0xFFFF_FFFF; mult1_P=0xFE01 every step -> done in cycle 17; product=0xFFFFFFFE_00000001; count_32bit seq 0..15.
REQ-037 start held high through RUN and DONE -> exactly one done per accepted start; the next start is accepted only in IDLE.
REQ-038 Two scenarios: sew=11 start -> err pulse, no busy; reset asserted at RUN step 2 of sew=10 -> all outputs 0 immediately, no done.
